// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared loader definitions: state encodings, byte order, limits.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_HI   = 3'd1,
        LD_LO   = 3'd2,
        LD_WR   = 3'd3,
        LD_CK   = 3'd4,
        LD_DONE = 3'd5
    } loader_state_t;

    // The first byte of each pair lands in the upper half of the word.
    localparam bit LOADER_HI_BYTE_FIRST = 1'b1;
    localparam int LOADER_MAX_WORDS     = 256;

    function automatic logic loader_is_busy(input loader_state_t s);
        return (s == LD_HI) || (s == LD_LO) || (s == LD_WR) || (s == LD_CK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_cksum.sv
// ============================================================================
// Module      : imem_loader_cksum
// Description : 8-bit modulo-256 byte accumulator with clear/add/compare.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imem_loader_cksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] add_data,
    input  logic [7:0] cmp_data,
    output logic       mismatch
);

    logic [7:0] r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= 8'h00;
        end else if (clr) begin
            r_sum <= 8'h00;
        end else if (add) begin
            r_sum <= r_sum + add_data;
        end
    end

    assign mismatch = (cmp_data != r_sum);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Boot-time byte-stream loader packing byte pairs into
//               instruction words; optional trailing checksum byte when
//               LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              cksum_err
);

    localparam logic [ADDR_W:0]   c_max_words = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_one_word  = 1;
    localparam logic [ADDR_W-1:0] c_addr_one  = 1;
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t     c_after_last = LD_CK;
`else
    localparam loader_state_t     c_after_last = LD_DONE;
`endif

    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W:0]   w_len_clamped;
    logic              w_start_acc;
    logic              w_last_word;

    assign w_len_clamped = (len > c_max_words) ? c_max_words : len;
    assign w_start_acc   = start && ((r_state == LD_IDLE) || (r_state == LD_DONE));
    assign w_last_word   = (r_words == c_one_word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LD_IDLE, LD_DONE: begin
                if (start) begin
                    w_next_state = (w_len_clamped == '0) ? c_after_last : LD_HI;
                end
            end
            LD_HI:   if (byte_valid) w_next_state = LD_LO;
            LD_LO:   if (byte_valid) w_next_state = LD_WR;
            LD_WR:   w_next_state = w_last_word ? c_after_last : LD_HI;
            LD_CK:   if (byte_valid) w_next_state = LD_DONE;
            default: w_next_state = LD_IDLE;
        endcase
    end

    // Address advances only between words, so the final write stays at the last slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_words <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_start_acc) begin
                r_words <= w_len_clamped;
                r_addr  <= '0;
            end
            if ((r_state == LD_HI) && byte_valid) begin
                r_wdata[DATA_W-1 -: 8] <= byte_data;
            end
            if ((r_state == LD_LO) && byte_valid) begin
                r_wdata[7:0] <= byte_data;
            end
            if (r_state == LD_WR) begin
                r_words <= r_words - c_one_word;
                if (!w_last_word) begin
                    r_addr <= r_addr + c_addr_one;
                end
            end
        end
    end

    assign byte_ready = (r_state == LD_HI) || (r_state == LD_LO) || (r_state == LD_CK);
    assign mem_we     = (r_state == LD_WR);
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign busy       = loader_is_busy(r_state);
    assign cpu_hold   = busy;
    assign done       = (r_state == LD_DONE);

`ifdef LOADER_CHECKSUM_EN
    logic w_ck_mismatch;
    logic w_data_hs;
    logic r_cksum_err;

    assign w_data_hs = byte_valid && ((r_state == LD_HI) || (r_state == LD_LO));

    imem_loader_cksum u_cksum (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_start_acc),
        .add      (w_data_hs),
        .add_data (byte_data),
        .cmp_data (byte_data),
        .mismatch (w_ck_mismatch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cksum_err <= 1'b0;
        end else if (w_start_acc) begin
            r_cksum_err <= 1'b0;
        end else if ((r_state == LD_CK) && byte_valid) begin
            r_cksum_err <= w_ck_mismatch;
        end
    end

    assign cksum_err = r_cksum_err;
`else
    assign cksum_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam int CK_EXTRA = 1;
`else
    localparam int CK_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        cksum_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    int          busy_cnt;
    int          ready_cnt;

    imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .cksum_err  (cksum_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (busy === 1'b1) busy_cnt++;
        if (byte_ready === 1'b1) ready_cnt++;
    end

    task automatic clear_log();
        @(posedge clk);
        #1;
        wr_addr.delete();
        wr_data.delete();
        busy_cnt  = 0;
        ready_cnt = 0;
    endtask

    task automatic do_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = l[8:0];
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] bytes[$], input bit toggle);
        int idx = 0;
        int cyc = 0;
        bit ph  = 1'b0;
        while (idx < bytes.size() && cyc < 5000) begin
            @(negedge clk);
            byte_valid = toggle ? ph : 1'b1;
            ph         = !ph;
            byte_data  = bytes[idx];
            if (byte_valid && byte_ready) idx++;
            cyc++;
        end
        n_checks++;
        if (idx != bytes.size()) begin
            n_fail++;
            $display("FAIL feed_timeout: consumed %0d bytes, required %0d", idx, bytes.size());
        end
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        byte_valid = 1'b0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic load(input int l, input logic [7:0] bytes[$], input bit toggle);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] s = 8'h00;
        foreach (bytes[i]) s = s + bytes[i];
        bytes.push_back(s);
`endif
        clear_log();
        do_start(l);
        feed(bytes, toggle);
        wait_done();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({byte_ready, mem_addr, mem_wdata, mem_we, cpu_hold, busy, done, cksum_err} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {byte_ready, mem_addr, mem_wdata, mem_we, cpu_hold, busy, done, cksum_err});
        end
        rst = 1'b0;
        byte_valid = 1'b1; byte_data = 8'h99;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({byte_ready, busy, done, mem_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_no_accept: ready/busy/done/we=%b, required 0000",
                     {byte_ready, busy, done, mem_we});
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        q.push_back(8'h12); q.push_back(8'h34); q.push_back(8'h56); q.push_back(8'h78);
        load(2, q, 1'b0);
        n_checks++;
        if (wr_addr.size() != 2) begin
            n_fail++; $display("FAIL basic_we_count: got %0d, required 2", wr_addr.size());
        end else begin
            n_checks++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 16'h1234) begin
                n_fail++; $display("FAIL basic_word0: got %h@%h, required 1234@00", wr_data[0], wr_addr[0]);
            end
            n_checks++;
            if (wr_addr[1] !== 8'd1 || wr_data[1] !== 16'h5678) begin
                n_fail++; $display("FAIL basic_word1: got %h@%h, required 5678@01", wr_data[1], wr_addr[1]);
            end
        end
        n_checks++;
        if (busy_cnt != 6 + CK_EXTRA) begin
            n_fail++; $display("FAIL basic_busy_cycles: got %0d, required %0d", busy_cnt, 6 + CK_EXTRA);
        end
        n_checks++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_release: hold/busy=%b%b, required 00", cpu_hold, busy);
        end
    endtask

    task automatic test_empty();
        logic [7:0] q[$];
        load(0, q, 1'b0);
        n_checks++;
        if (wr_addr.size() != 0) begin
            n_fail++; $display("FAIL empty_we_count: got %0d, required 0", wr_addr.size());
        end
        n_checks++;
        if (ready_cnt != CK_EXTRA) begin
            n_fail++; $display("FAIL empty_ready: got %0d ready cycles, required %0d", ready_cnt, CK_EXTRA);
        end
        n_checks++;
        if (busy_cnt != CK_EXTRA) begin
            n_fail++; $display("FAIL empty_busy: got %0d busy cycles, required %0d", busy_cnt, CK_EXTRA);
        end
    endtask

    task automatic test_stall();
        logic [7:0]  q[$];
        logic [15:0] exp_w[3];
        exp_w[0] = 16'hA1B2; exp_w[1] = 16'hC3D4; exp_w[2] = 16'hE5F6;
        q.push_back(8'hA1); q.push_back(8'hB2); q.push_back(8'hC3);
        q.push_back(8'hD4); q.push_back(8'hE5); q.push_back(8'hF6);
        load(3, q, 1'b1);
        n_checks++;
        if (wr_addr.size() != 3) begin
            n_fail++; $display("FAIL stall_we_count: got %0d, required 3", wr_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (wr_addr[k] !== k[7:0] || wr_data[k] !== exp_w[k]) begin
                    n_fail++;
                    $display("FAIL stall_word%0d: got %h@%h, required %h@%h",
                             k, wr_data[k], wr_addr[k], exp_w[k], k[7:0]);
                end
            end
        end
    endtask

    task automatic test_full_load(input int l);
        logic [7:0] q[$];
        int errs = 0;
        for (int k = 0; k < 256; k++) begin
            q.push_back(k[7:0]);
            q.push_back(~k[7:0]);
        end
        load(l, q, 1'b0);
        n_checks++;
        if (wr_addr.size() != 256) begin
            n_fail++; $display("FAIL full%0d_we_count: got %0d, required 256", l, wr_addr.size());
        end else begin
            for (int k = 0; k < 256; k++) begin
                if (wr_addr[k] !== k[7:0] || wr_data[k] !== {k[7:0], ~k[7:0]}) errs++;
            end
            n_checks++;
            if (errs != 0) begin
                n_fail++; $display("FAIL full%0d_sequence: %0d bad words, required 0", l, errs);
            end
            n_checks++;
            if (wr_addr[255] !== 8'hFF || wr_data[255] !== 16'hFF00) begin
                n_fail++; $display("FAIL full%0d_last: got %h@%h, required ff00@ff", l, wr_data[255], wr_addr[255]);
            end
        end
        n_checks++;
        if (busy_cnt != 768 + CK_EXTRA) begin
            n_fail++; $display("FAIL full%0d_busy: got %0d, required %0d", l, busy_cnt, 768 + CK_EXTRA);
        end
    endtask

    task automatic test_checksum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] q[$];
        q.push_back(8'hA0); q.push_back(8'h05); q.push_back(8'hA5);
        clear_log(); do_start(1); feed(q, 1'b0); wait_done();
        n_checks++;
        if (cksum_err !== 1'b0) begin
            n_fail++; $display("FAIL cksum_good: got %b, required 0", cksum_err);
        end
        q[2] = 8'hA4;
        clear_log(); do_start(1); feed(q, 1'b0); wait_done();
        n_checks++;
        if (cksum_err !== 1'b1) begin
            n_fail++; $display("FAIL cksum_bad: got %b, required 1", cksum_err);
        end
`else
        logic [7:0] q[$];
        q.push_back(8'hA0); q.push_back(8'h05);
        load(1, q, 1'b0);
        n_checks++;
        if (cksum_err !== 1'b0) begin
            n_fail++; $display("FAIL cksum_tied: got %b, required 0", cksum_err);
        end
`endif
    endtask

    task automatic test_reset_midload();
        logic [7:0] q[$];
        clear_log();
        do_start(1);
        @(negedge clk);
        byte_valid = 1'b1; byte_data = 8'hFF;
        @(negedge clk);
        byte_valid = 1'b0;
        n_checks++;
        if (byte_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midload_in_lo: ready/busy=%b%b, required 11", byte_ready, busy);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({byte_ready, mem_addr, mem_wdata, mem_we, cpu_hold, busy, done, cksum_err} !== 30'd0) begin
            n_fail++;
            $display("FAIL midload_reset_outputs: got %h, required 0",
                     {byte_ready, mem_addr, mem_wdata, mem_we, cpu_hold, busy, done, cksum_err});
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (wr_addr.size() != 0) begin
            n_fail++; $display("FAIL midload_no_write: got %0d writes, required 0", wr_addr.size());
        end
        q.push_back(8'h11); q.push_back(8'h22);
        load(1, q, 1'b0);
        n_checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 16'h1122) begin
            n_fail++;
            $display("FAIL midload_reload: got %0d writes first %h@%h, required 1 write 1122@00",
                     wr_addr.size(), wr_data[0], wr_addr[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_stall();
        test_full_load(256);
        test_full_load(300);
        test_checksum();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the instruction memory's write port. It accepts a byte stream over a valid/ready handshake, packs byte pairs into 16-bit instruction words (high byte first), and issues one single-cycle write per word at consecutive addresses from 0. While loading, it holds the CPU core off the instruction memory.

## Interface
Parameters:
- ADDR_W, 8, instruction memory address width.
- DATA_W, 16, instruction word width; fixed at 2 bytes.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  one clock; reset is asynchronous and active-high.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE/DONE.
- len  in  ADDR_W+1  number of words to load, sampled with start; 0 = empty load; values >256 clamp to 256.
- byte_valid  in  1  upstream byte available.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  loader accepts byte this cycle.
- mem_addr  out  ADDR_W  instruction memory write address.
- mem_wdata  out  DATA_W  instruction word to write.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- cpu_hold  out  1  core must not fetch while high.
- busy  out  1  load in progress.
- done  out  1  last load completed; level, cleared by next accepted start.
- cksum_err  out  1  checksum mismatch on last load (checksum build only).

## Operation
- States: IDLE, HI, LO, WR, CK (checksum build only), DONE.
- IDLE/DONE + start: latch clamped len into word counter, clear addr to 0, clear done/cksum_err; go HI, or go DONE directly if len==0.
- HI: byte_ready=1; on byte_valid&byte_ready, store byte into mem_wdata[15:8], go LO.
- LO: byte_ready=1; on handshake, store byte into mem_wdata[7:0], go WR.
- WR: mem_we=1 for exactly one cycle with stable mem_addr/mem_wdata; decrement word counter; if counter was 1, go CK (checksum build) or DONE; else increment mem_addr, go HI.
- DONE: done=1, cpu_hold=0; re-armable by start.
- start in HI/LO/WR/CK is ignored.
- byte_ready is 0 in IDLE, WR, DONE; bytes offered there are not consumed.
- mem_addr never wraps: max word count 256 ends at address 255.
- cpu_hold = busy = (state ∈ {HI, LO, WR, CK}).

## Timing
- Reset values: byte_ready 0, mem_addr 0, mem_wdata 0, mem_we 0, cpu_hold 0, busy 0, done 0, cksum_err 0; state IDLE.
- Reset mid-load aborts immediately; no partial word is written; memory contents already written are left as-is.
- With byte_valid held high, one word takes 3 cycles (HI, LO, WR); N words: busy for 3N cycles (+1 for CK).
- mem_we asserts the cycle after the low-byte handshake.
- start→busy: 1 cycle. Final WR (or CK) → done: 1 cycle.
- Upstream stalls (byte_valid=0) hold state indefinitely with no output change.

## Configuration
- LOADER_CHECKSUM_EN defined: after the last WR, state CK asserts byte_ready and accepts one extra byte; cksum_err set if it differs from the 8-bit modulo-256 sum of all data bytes in this load; then DONE. For len==0 the expected sum is 0 and CK is still entered.
- Undefined: no CK state, no accumulator, cksum_err tied to 0; WR goes straight to DONE.

## Structure
- Shared define header (same one holding CPU opcode/register defines) gets: loader state encodings (3-bit), byte-order constant (high byte first), LOADER_MAX_WORDS = 256.
- One sub-module: imem_loader_cksum (8-bit accumulator with clear/add/compare), instantiated only under LOADER_CHECKSUM_EN.

## Test plan
- len=2, bytes 0x12,0x34,0x56,0x78 back-to-back -> mem_we pulses at addr 0 data 0x1234 and addr 1 data 0x5678; done after 6 busy cycles.
- len=0 start -> done next cycle, no mem_we, byte_ready never high.
- len=3 with byte_valid toggled every other cycle -> same three words written, no duplicate or dropped bytes, mem_we exactly 3 pulses.
- len=256 continuous stream -> last write at addr 255, no wrap; len=300 behaves identically.
- Checksum build: len=1 bytes 0xA0,0x05 then 0xA5 -> cksum_err 0; repeat with 0xA4 -> cksum_err 1.
- rst asserted in LO after high byte 0xFF accepted -> all outputs to reset values, no mem_we; subsequent start with len=1 loads cleanly at addr 0.
